// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [31:0] pcplus4;
        logic [31:0] instr;
    } fetch_pkt_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry holding register for a word fetched while decode is stalled.
module if_hold_buf
    import if_fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       clear_i,
    input  fetch_pkt_t data_i,
    output logic       valid_o,
    output fetch_pkt_t data_o
);

    logic       valid_q, valid_d;
    fetch_pkt_t data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, talks req/ack to imem and writes
// the IF/ID register, with a one-word stall buffer and redirect flushing.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PCplus4,
    output logic [31:0] Instruction,
    output logic        inst_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    fetch_pkt_t   out_q, out_d;
    logic         vld_q, vld_d;

    logic         buf_load, buf_clear, buf_valid;
    fetch_pkt_t   buf_data, fetched;
    logic [31:0]  pc_next, redir_tgt;

    assign pc_next   = pc_q + PC_INCR;
    assign redir_tgt = align_pc(redirect_pc);
    assign fetched   = '{pcplus4: pc_next, instr: imem_rdata};

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (fetched),
        .valid_o (buf_valid),
        .data_o  (buf_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (redirect_valid)      state_d = imem_ack ? S_FETCH : S_DISCARD;
                else if (imem_ack && stall) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid || !stall) state_d = S_FETCH;
            end
            S_DISCARD: begin
                if (imem_ack) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath next-state; a redirect always bubbles the outputs, stall alone freezes them.
    always_comb begin
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        out_d     = out_q;
        vld_d     = vld_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (redirect_valid) begin
            out_d = '{pcplus4: 32'h0, instr: NOP};
            vld_d = 1'b0;
        end
        unique case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) pc_d  = redir_tgt;
                    else          tgt_d = redir_tgt;
                end else if (imem_ack) begin
                    pc_d = pc_next;
                    if (stall) begin
                        buf_load = 1'b1;
                    end else begin
                        out_d = fetched;
                        vld_d = 1'b1;
                    end
                end else if (!stall) begin
                    out_d = '{pcplus4: 32'h0, instr: NOP};
                    vld_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    buf_clear = 1'b1;
                    pc_d      = redir_tgt;
                end else if (!stall) begin
                    buf_clear = 1'b1;
                    out_d     = buf_data;
                    vld_d     = buf_valid;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) tgt_d = redir_tgt;
                if (imem_ack)       pc_d  = redirect_valid ? redir_tgt : tgt_q;
                if (!redirect_valid && !stall) begin
                    out_d = '{pcplus4: 32'h0, instr: NOP};
                    vld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            tgt_q <= RESET_PC;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            tgt_q <= tgt_d;
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign imem_req    = rst && (state_q == S_FETCH || state_q == S_DISCARD);
    assign imem_addr   = pc_q;
    assign PCplus4     = out_q.pcplus4;
    assign Instruction = out_q.instr;
    assign inst_valid  = vld_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall/hold, redirects, wrap, resets.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] PCplus4;
    logic [31:0] Instruction;
    logic        inst_valid;

    int tests = 0;
    int fails = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .PCplus4        (PCplus4),
        .Instruction    (Instruction),
        .inst_valid     (inst_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] p4, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, v});
        chk({tag, ".instr"}, Instruction, ins);
        chk({tag, ".pcp4"},  PCplus4, p4);
        chk({tag, ".addr"},  imem_addr, addr);
    endtask

    initial begin
        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst.req", {31'b0, imem_req}, 32'd0);
        chk_out("rst", 1'b0, 32'h0, 32'h0, 32'h0);

        // Zero-wait streaming
        rst = 1'b1; #1;
        chk("start.req", {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000 ^ 32'hA5A5_0000;
        tick();
        chk_out("s0", 1'b1, 32'hA5A5_0000, 32'd4, 32'd4);
        imem_rdata = 32'h0000_0004 ^ 32'hA5A5_0000;
        tick();
        chk_out("s1", 1'b1, 32'hA5A5_0004, 32'd8, 32'd8);

        // Stall while word@8 arrives
        stall = 1'b1; imem_rdata = 32'h0000_0008 ^ 32'hA5A5_0000;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("hold.req", {31'b0, imem_req}, 32'd0);
        chk_out("hold0", 1'b1, 32'hA5A5_0004, 32'd8, 32'd12);
        tick();
        tick();
        chk_out("hold2", 1'b1, 32'hA5A5_0004, 32'd8, 32'd12);
        chk("hold2.req", {31'b0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk_out("unhold", 1'b1, 32'hA5A5_0008, 32'd12, 32'd12);
        chk("unhold.req", {31'b0, imem_req}, 32'd1);

        // Redirect in same cycle as ack of word@16
        imem_ack = 1'b1; imem_rdata = 32'h0000_000C ^ 32'hA5A5_0000;
        tick();
        chk_out("s3", 1'b1, 32'hA5A5_000C, 32'd16, 32'd16);
        imem_rdata = 32'h0000_0010 ^ 32'hA5A5_0000;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        chk_out("redir_ack", 1'b0, 32'h0, 32'h0, 32'h0000_0100);

        // Go to 0x20, then redirect to 0x40 while request is in flight
        redirect_pc = 32'h0000_0020;
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        chk("to20.addr", imem_addr, 32'h20);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("disc.req", {31'b0, imem_req}, 32'd1);
        chk_out("disc0", 1'b0, 32'h0, 32'h0, 32'h20);
        tick();
        chk("disc1.addr", imem_addr, 32'h20);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk_out("disc_ack", 1'b0, 32'h0, 32'h0, 32'h40);
        chk("disc_ack.req", {31'b0, imem_req}, 32'd1);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; imem_rdata = 32'h1234_5678;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap", 1'b1, 32'h1234_5678, 32'h0, 32'h0);

        // Reset during an outstanding fetch
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        tick();
        chk("out.addr", imem_addr, 32'h200);
        rst = 1'b0; #1;
        chk("rst_out.req", {31'b0, imem_req}, 32'd0);
        tick();
        chk_out("rst_out", 1'b0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1; #1;
        chk("rst_out.req1", {31'b0, imem_req}, 32'd1);

        // Reset during HOLD: held word must never appear
        imem_ack = 1'b1; imem_rdata = 32'h0000_0011;
        tick();
        chk_out("pre_hold", 1'b1, 32'h11, 32'd4, 32'd4);
        stall = 1'b1; imem_rdata = 32'h0000_0022;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("hold_b.req", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        tick();
        chk_out("rst_hold", 1'b0, 32'h0, 32'h0, 32'h0);
        rst = 1'b1; stall = 1'b0;
        tick();
        chk_out("post_rst", 1'b0, 32'h0, 32'h0, 32'h0);
        chk("post_rst.req", {31'b0, imem_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
